// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared op codes, state encoding and decode helpers for lsu_mem_ctrl
package lsu_pkg;

    localparam logic [5:0] SEL_LB  = 6'b001011;
    localparam logic [5:0] SEL_LH  = 6'b001100;
    localparam logic [5:0] SEL_LW  = 6'b001101;
    localparam logic [5:0] SEL_LBU = 6'b001110;
    localparam logic [5:0] SEL_LHU = 6'b001111;
    localparam logic [5:0] SEL_SB  = 6'b010000;
    localparam logic [5:0] SEL_SH  = 6'b010001;
    localparam logic [5:0] SEL_SW  = 6'b010010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    function automatic logic is_load(input logic [5:0] sel);
        case (sel)
            SEL_LB, SEL_LH, SEL_LW, SEL_LBU, SEL_LHU: is_load = 1'b1;
            default:                                  is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] sel);
        case (sel)
            SEL_SB, SEL_SH, SEL_SW: is_store = 1'b1;
            default:                is_store = 1'b0;
        endcase
    endfunction

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [5:0] sel, input logic [1:0] lo);
        case (sel)
            SEL_LH, SEL_LHU, SEL_SH: is_misaligned = lo[0];
            SEL_LW, SEL_SW:          is_misaligned = |lo;
            default:                 is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_align.sv
// rtl/lsu_mem_ctrl_load_align.sv - byte/halfword select and extension of a read word
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [5:0]  sel,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // Move the addressed lane down to bit 0, then extend according to the op.
    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (sel)
            SEL_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
            SEL_LBU: result = {24'h0, shifted[7:0]};
            SEL_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
            SEL_LHU: result = {16'h0, shifted[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - MEM-stage load/store controller with request/ready/rvalid handshake
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    input  logic [5:0]  alu_select,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    import lsu_pkg::*;

    // The counter never needs to hold TIMEOUT_CYCLES itself: the access is
    // abandoned in the cycle where it sits at TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [5:0]    sel_q;
    logic [1:0]    lo_q;
    logic [29:0]   waddr_q;
    logic          we_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   wdata_q;
    logic [CW-1:0] cnt;
    logic          misalign_q;
    logic          bus_err_q;
    logic [31:0]   load_data_q;
    logic [31:0]   rdata_ext;

    logic          mem_op;
    logic          mis;
    logic [3:0]    nxt_wstrb;
    logic [31:0]   nxt_wdata;

    // Decode the incoming op: validity, alignment and the store lane pattern.
    always_comb begin
        mem_op    = is_load(alu_select) | is_store(alu_select);
        mis       = is_misaligned(alu_select, addr[1:0]);
        nxt_wstrb = 4'b0000;
        nxt_wdata = store_data;
        case (alu_select)
            SEL_SB: begin
                nxt_wstrb = 4'b0001 << addr[1:0];
                nxt_wdata = {4{store_data[7:0]}};
            end
            SEL_SH: begin
                nxt_wstrb = 4'b0011 << addr[1:0];
                nxt_wdata = {2{store_data[15:0]}};
            end
            SEL_SW: begin
                nxt_wstrb = 4'b1111;
                nxt_wdata = store_data;
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (lo_q),
        .sel     (sel_q),
        .result  (rdata_ext)
    );

    // Access sequencer: latch the op, run the handshake, time out stuck accesses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            sel_q       <= 6'd0;
            lo_q        <= 2'd0;
            waddr_q     <= 30'd0;
            we_q        <= 1'b0;
            wstrb_q     <= 4'd0;
            wdata_q     <= 32'd0;
            cnt         <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            load_data_q <= 32'd0;
        end else begin
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op_valid && mem_op) begin
                        if (mis) begin
                            misalign_q <= 1'b1;
                            state      <= ST_ERR;
                        end else begin
                            sel_q   <= alu_select;
                            lo_q    <= addr[1:0];
                            waddr_q <= addr[31:2];
                            we_q    <= is_store(alu_select);
                            wstrb_q <= nxt_wstrb;
                            wdata_q <= nxt_wdata;
                            cnt     <= '0;
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ready) begin
                        state <= we_q ? ST_DONE : ST_WAIT;
                    end else if (cnt == TO_LAST) begin
                        bus_err_q <= 1'b1;
                        state     <= ST_ERR;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_rvalid) begin
                        load_data_q <= rdata_ext;
                        state       <= ST_DONE;
                    end else if (cnt == TO_LAST) begin
                        bus_err_q <= 1'b1;
                        state     <= ST_ERR;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are pure state decodes or registers; stall also looks ahead at the op in IDLE.
    always_comb begin
        stall        = (state == ST_REQ) || (state == ST_WAIT) ||
                       ((state == ST_IDLE) && op_valid && mem_op && !mis);
        done         = (state == ST_DONE);
        misalign_err = misalign_q;
        bus_err      = bus_err_q;
        load_data    = load_data_q;
        mem_req      = (state == ST_REQ);
        mem_we       = we_q;
        mem_addr     = {waddr_q, 2'b00};
        mem_wstrb    = wstrb_q;
        mem_wdata    = wdata_q;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Multi-cycle data-memory access controller for the MEM stage. It takes the effective address and the 6-bit ALU select code of a load or store, then runs a request/ready/rvalid handshake with the data memory. Along the way it generates byte strobes and aligned write data, and it extracts and sign/zero-extends load data. It holds the pipeline stall until the access completes, and flags misaligned accesses and memory timeouts.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in REQ or WAIT before the access is abandoned with `bus_err`.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset_n`  in  1  — synchronous, active-low reset.
- `op_valid`  in  1  — MEM-stage instruction valid.
- `alu_select`  in  6  — op code. 001011 LB, 001100 LH, 001101 LW, 001110 LBU, 001111 LHU, 010000 SB, 010001 SH, 010010 SW. Any other value is a non-memory op.
- `addr`  in  32  — effective address (rs1 + imm).
- `store_data`  in  32  — rs2 value.
- `stall`  out  1  — freeze the pipeline upstream of MEM.
- `done`  out  1  — one-cycle pulse when an access completes.
- `load_data`  out  32  — extended load result; valid while `done` is high.
- `misalign_err`  out  1  — one-cycle pulse for a misaligned access.
- `bus_err`  out  1  — one-cycle pulse when a timeout occurs.
- `mem_req`  out  1  — memory request.
- `mem_we`  out  1  — request is a write.
- `mem_addr`  out  32  — word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wstrb`  out  4  — byte-lane write enables.
- `mem_wdata`  out  32  — lane-replicated store data.
- `mem_ready`  in  1  — memory accepts the request in this cycle.
- `mem_rvalid`  in  1  — read data valid.
- `mem_rdata`  in  32  — read data word.

## Operation
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - Trigger: `op_valid` with a memory code.
  - Alignment checks: LH/LHU/SH need `addr[0]==0`; LW/SW need `addr[1:0]==0`.
  - Misaligned → ERR and set `misalign_err`.
  - Aligned → latch op, `addr[1:0]`, strobes and write data, then go to REQ.
  - Non-memory codes are ignored; the FSM stays in IDLE.
- REQ:
  - `mem_req=1`; `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata` are held stable.
  - On `mem_ready`: a store goes to DONE; a load goes to WAIT.
- WAIT:
  - On `mem_rvalid`: capture the extended `mem_rdata` into `load_data`, then go to DONE.
  - `mem_rvalid` is ignored in every other state.
- DONE: `done=1` for one cycle, then IDLE.
- ERR: one cycle, then IDLE. No memory request is ever issued for a misaligned access.
- Timeout:
  - The counter clears on entry to REQ and increments in REQ and WAIT.
  - When it reaches `TIMEOUT_CYCLES`, `bus_err` pulses, `mem_req` drops, and the FSM goes to ERR. On this path `misalign_err` stays low.
- Stores:
  - SB: `wstrb = 4'b0001 << addr[1:0]`, `wdata = {4{sd[7:0]}}`.
  - SH: `wstrb = 4'b0011 << addr[1:0]`, `wdata = {2{sd[15:0]}}`.
  - SW: `wstrb = 4'b1111`.
- Loads: the byte or halfword is selected by the latched `addr[1:0]`. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- `stall` is combinational:
  - High when `state ∈ {REQ, WAIT}`.
  - Also high in IDLE when `op_valid` and the op is an aligned memory op.
  - Low in DONE and ERR, so the pipeline advances in the same cycle that `done` or an error pulse is high.
- Reset: all outputs are 0 and the state is IDLE. A reset mid-access abandons the access; the controller does not wait for pending `mem_rvalid`.

## Timing
- `done`, `load_data`, `misalign_err`, `bus_err`, and all `mem_*` outputs are registered or decoded from state. Nothing from the memory side reaches them combinationally.
- Store with zero wait: op in cycle 0, `mem_req` in cycle 1 with `mem_ready=1`, `done` in cycle 2. Minimum latency is 2 cycles.
- Load with zero wait: `mem_req` in cycle 1, `mem_rvalid` in cycle 2, `done` and `load_data` in cycle 3. Minimum latency is 3 cycles.
- `mem_rvalid` arriving in the same cycle as `mem_ready` is not accepted; it must arrive at least one cycle after `mem_ready`.
- Back-to-back ops: a new op can be accepted in the IDLE cycle after DONE. Throughput is therefore one access per 3 cycles (store) or 4 cycles (load).
- Misaligned op: `misalign_err` in cycle 1, IDLE in cycle 2.

## Structure
- Package `lsu_pkg` holds:
  - the 6-bit select constants (`SEL_LB` … `SEL_SW`);
  - the state enum;
  - the helper functions `is_load`, `is_store`, `is_misaligned`.
- Sub-module `load_align`: a combinational block from `rdata`, `addr[1:0]` and op to the 32-bit extended result. It is instantiated once.

## Test plan
- SW `addr=0x100`, `sd=0xDEADBEEF`, `mem_ready` in the first REQ cycle:
  - `mem_req` in cycle 1, `wstrb=1111`, `mem_addr=0x100`;
  - `done` in cycle 2;
  - `stall` high in cycles 0–1.
- SB `addr=0x103`, `sd=0x000000AB`: `wstrb=1000`, `wdata=0xABABABAB`, `mem_addr=0x100`.
- Loads with `mem_rdata=0x80FF7F01`:
  - LB `addr+2` → `load_data=0xFFFFFFFF`;
  - LBU `addr+3` → `0x00000080`;
  - LH `addr+2` → `0xFFFF80FF`;
  - LHU `addr+0` → `0x00007F01`.
- LW `addr=0x102`: `misalign_err` pulse in cycle 1, `mem_req` never asserted, IDLE in cycle 2.
- Load with `mem_ready` delayed 3 cycles and `mem_rvalid` delayed 2 more: `stall` held throughout, `done` exactly 1 cycle after `mem_rvalid`.
- Timeout and reset:
  - `TIMEOUT_CYCLES=4` with `mem_ready` held low: `bus_err` pulses and `mem_req` deasserts.
  - `reset_n` low during WAIT: IDLE with all outputs 0 on the next edge.
